// File: rtl/pipelined_cla_subtractor.sv
// Two-stage 8-bit subtractor d = a - b - bin on a valid/ready stream.
// Stage 1 resolves the low 4-bit lookahead group; stage 2 resolves the high group and the flags.
module pipelined_cla_subtractor (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       bin,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] d,
    output logic       bout,
    output logic       ovf
);

    // Full lookahead for one 4-bit group: c[0] is the group carry-in and c[4] the carry-out.
    function automatic logic [4:0] cla_carries(input logic [3:0] g, input logic [3:0] p, input logic c0);
        logic [4:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    logic [3:0] s1_d_lo_reg;
    logic       s1_c4_reg;
    logic [3:0] s1_a_hi_reg;
    logic [3:0] s1_b_hi_reg;
    logic       s1_valid_reg;

    logic [7:0] d_reg;
    logic       bout_reg;
    logic       ovf_reg;
    logic       s2_valid_reg;

    logic [3:0] g_lo, p_lo, g_hi, p_hi;
    logic [4:0] c_lo, c_hi;
    logic [3:0] sum_lo, sum_hi;
    logic       s2_free, s1_adv, in_fire;
    logic       s1_valid_next, s2_valid_next;

    // Subtraction as a + ~b + ~bin: generate/propagate use the inverted subtrahend.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_gp
            assign g_lo[gi] = a[gi] & ~b[gi];
            assign p_lo[gi] = a[gi] ^ ~b[gi];
            assign g_hi[gi] = s1_a_hi_reg[gi] & ~s1_b_hi_reg[gi];
            assign p_hi[gi] = s1_a_hi_reg[gi] ^ ~s1_b_hi_reg[gi];
        end
    endgenerate

    assign c_lo   = cla_carries(g_lo, p_lo, ~bin);
    assign sum_lo = p_lo ^ c_lo[3:0];
    assign c_hi   = cla_carries(g_hi, p_hi, s1_c4_reg);
    assign sum_hi = p_hi ^ c_hi[3:0];

    assign s2_free  = !s2_valid_reg || out_ready;
    assign s1_adv   = s1_valid_reg && s2_free;
    assign in_ready = !rst && (!s1_valid_reg || s2_free);
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        s1_valid_next = s1_valid_reg;
        if (in_fire)
            s1_valid_next = 1'b1;
        else if (s1_adv)
            s1_valid_next = 1'b0;

        s2_valid_next = s2_valid_reg;
        if (s1_adv)
            s2_valid_next = 1'b1;
        else if (out_ready)
            s2_valid_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_d_lo_reg  <= 4'h0;
            s1_c4_reg    <= 1'b0;
            s1_a_hi_reg  <= 4'h0;
            s1_b_hi_reg  <= 4'h0;
            s2_valid_reg <= 1'b0;
            d_reg        <= 8'h00;
            bout_reg     <= 1'b0;
            ovf_reg      <= 1'b0;
        end else begin
            s1_valid_reg <= s1_valid_next;
            s2_valid_reg <= s2_valid_next;
            if (in_fire) begin
                s1_d_lo_reg <= sum_lo;
                s1_c4_reg   <= c_lo[4];
                s1_a_hi_reg <= a[7:4];
                s1_b_hi_reg <= b[7:4];
            end
            // Output registers only change on advance, so a stalled result stays bit-stable.
            if (s1_adv) begin
                d_reg    <= {sum_hi, s1_d_lo_reg};
                bout_reg <= ~c_hi[4];
                ovf_reg  <= c_hi[4] ^ c_hi[3];
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign d         = d_reg;
    assign bout      = bout_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_pipelined_cla_subtractor.sv
// Self-checking bench for pipelined_cla_subtractor: directed cases, random streaming,
// back-pressure and mid-stream reset, scored against an integer-arithmetic model.
module tb_pipelined_cla_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] d;
    logic       bout;
    logic       ovf;

    pipelined_cla_subtractor dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       bout;
        logic       ovf;
        int         cyc;
    } exp_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc_cnt = 0;
    int   n_out = 0;
    int   n_in = 0;
    bit   chk_lat = 1'b0;
    exp_t sb[$];

    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic c);
        exp_t m;
        int diff;
        diff   = int'(x) - int'(y) - int'(c);
        m.d    = diff[7:0];
        m.bout = (diff < 0);
        m.ovf  = (x[7] != y[7]) && (m.d[7] != x[7]);
        m.cyc  = 0;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: score handshakes at the falling edge, then advance past the rising edge.
    task automatic cycle(output bit acc);
        exp_t e;
        @(negedge clk);
        acc = 1'b0;
        if (out_valid && out_ready) begin
            n_out++;
            chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("stream_d", 32'(d), 32'(e.d));
                chk("stream_bout", 32'(bout), 32'(e.bout));
                chk("stream_ovf", 32'(ovf), 32'(e.ovf));
                if (chk_lat) chk("latency", 32'(cyc_cnt - e.cyc), 32'd2);
            end
        end
        if (in_valid && in_ready) begin
            e = model(a, b, bin);
            e.cyc = cyc_cnt;
            sb.push_back(e);
            n_in++;
            acc = 1'b1;
        end
        @(posedge clk);
        cyc_cnt++;
        #1;
    endtask

    task automatic directed(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                            input logic tbin, input logic [7:0] ed, input logic eb, input logic eo);
        a = ta; b = tb_v; bin = tbin; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        @(negedge clk);
        chk({tag, "_valid_early"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_d"}, 32'(d), 32'(ed));
        chk({tag, "_bout"}, 32'(bout), 32'(eb));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
        $display("directed %s: a=%0d b=%0d bin=%0d -> d=%02h bout=%0d ovf=%0d", tag, ta, tb_v, tbin, d, bout, ovf);
        @(posedge clk); #1;
    endtask

    initial begin
        bit acc;
        int idx;
        logic [7:0] bp_a[4];
        logic [7:0] bp_b[4];
        logic       bp_c[4];

        rst = 1'b1; in_valid = 1'b1; a = 8'h12; b = 8'h34; bin = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_d", 32'(d), 32'd0);
        chk("reset_bout", 32'(bout), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;

        directed("sub_31_16", 8'd31, 8'd16, 1'b0, 8'd15, 1'b0, 1'b0);
        directed("sub_68_31_b", 8'd68, 8'd31, 1'b1, 8'd36, 1'b0, 1'b0);
        directed("wrap_15_16", 8'd15, 8'd16, 1'b0, 8'hFF, 1'b1, 1'b0);
        directed("wrap_0_0_b", 8'd0, 8'd0, 1'b1, 8'hFF, 1'b1, 1'b0);
        directed("ovf_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        directed("ovf_7f_ff", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

        // Streaming: 16 back-to-back random beats with the consumer always ready.
        chk_lat = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom); in_valid = 1'b1;
            #1;
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            cycle(acc);
            $display("stream beat %0d: a=%02h b=%02h accepted=%0d", i, a, b, acc);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle(acc);
        chk("stream_drained", 32'(sb.size()), 32'd0);
        chk("stream_count", 32'(n_out), 32'd16);
        chk_lat = 1'b0;

        // Back-pressure: offer 4 beats with the consumer stalled; only 2 fit.
        for (int i = 0; i < 4; i++) begin
            bp_a[i] = 8'($urandom); bp_b[i] = 8'($urandom); bp_c[i] = 1'($urandom);
        end
        n_in = 0; n_out = 0; idx = 0; out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = (idx < 4);
            a = bp_a[idx % 4]; b = bp_b[idx % 4]; bin = bp_c[idx % 4];
            if (out_valid && sb.size() > 0) chk("hold_d", 32'(d), 32'(sb[0].d));
            cycle(acc);
            if (acc) idx++;
            $display("backpressure stall cycle %0d: accepted=%0d total=%0d", i, acc, idx);
        end
        chk("bp_accepted", 32'(idx), 32'd2);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (idx < 4 || sb.size() > 0); i++) begin
            in_valid = (idx < 4);
            a = bp_a[idx % 4]; b = bp_b[idx % 4]; bin = bp_c[idx % 4];
            cycle(acc);
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("bp_all_in", 32'(n_in), 32'd4);
        chk("bp_all_out", 32'(n_out), 32'd4);
        chk("bp_drained", 32'(sb.size()), 32'd0);
        $display("backpressure released: in=%0d out=%0d", n_in, n_out);

        // Reset with both stages full.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            cycle(acc);
        end
        chk("pre_reset_full", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_reset_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; sb.delete();
        @(negedge clk);
        chk("post_reset_out_valid", 32'(out_valid), 32'd0);
        chk("post_reset_d", 32'(d), 32'd0);
        chk("post_reset_bout", 32'(bout), 32'd0);
        chk("post_reset_ovf", 32'(ovf), 32'd0);
        $display("reset mid-stream: out_valid=%0d d=%02h", out_valid, d);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("no_stale_beat", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        directed("after_reset_5_3", 8'd5, 8'd3, 1'b0, 8'd2, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
